muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer that owns the write side of the HI/LO register pair in the multicycle CPU.
- Accepts MULT/MULTU/DIV/DIVU operands from the decode/execute path and runs a 32-step shift-add or restoring-divide loop.
- Issues a single-cycle 64-bit write command to HI/LO when the loop finishes.
- Stalls MFHI/MFLO reads while an operation is in flight.

---
 rtl/muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_muldiv_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// ============================================================================
// Module   : muldiv_seq
// Purpose  : Iterative MULT/MULTU/DIV/DIVU sequencer driving the HI/LO write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mf_req,
    output logic             busy,
    output logic             stall,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIX   = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam logic [1:0] c_op_mult = 2'b00;
    localparam logic [1:0] c_op_div  = 2'b10;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_sign_a;
    logic                 r_neg;
    logic                 r_div_zero;

    // Signed ops have op[0]==0; magnitude of 0x80000000 is exact as unsigned.
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    assign w_a_neg = src_a[WIDTH-1] & ~op[0];
    assign w_b_neg = src_b[WIDTH-1] & ~op[0];
    assign w_a_mag = w_a_neg ? (~src_a + 1'b1) : src_a;
    assign w_b_mag = w_b_neg ? (~src_b + 1'b1) : src_b;

    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Partial remainder needs one extra bit after the left shift.
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_rem_diff;
    logic                 w_rem_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_rem_diff = w_rem_sh - {1'b0, r_b};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_b});
    assign w_div_next = w_rem_ge ? {w_rem_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                 : {r_acc[2*WIDTH-2:0], 1'b0};

    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_a_raw;
    assign w_prod_fix = (r_op == c_op_mult && r_neg) ? (~r_acc + 1'b1) : r_acc;
    assign w_quo_fix  = (r_op == c_op_div && r_neg) ? (~r_acc[WIDTH-1:0] + 1'b1)
                                                    : r_acc[WIDTH-1:0];
    assign w_rem_fix  = (r_op == c_op_div && r_sign_a) ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1)
                                                       : r_acc[2*WIDTH-1:WIDTH];
    assign w_a_raw    = r_sign_a ? (~r_a + 1'b1) : r_a;

    assign busy  = (r_state != IDLE);
    assign stall = busy & mf_req;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_sign_a   <= 1'b0;
            r_neg      <= 1'b0;
            r_div_zero <= 1'b0;
            hilo_we    <= 1'b0;
            hi_wdata   <= '0;
            lo_wdata   <= '0;
        end else begin
            hilo_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_a        <= w_a_mag;
                        r_b        <= w_b_mag;
                        r_sign_a   <= w_a_neg;
                        r_neg      <= w_a_neg ^ w_b_neg;
                        r_div_zero <= op[1] & (src_b == '0);
                        r_acc      <= op[1] ? {{WIDTH{1'b0}}, w_a_mag} : '0;
                        r_cnt      <= '0;
                        r_state    <= CALC;
                    end
                end
                CALC: begin
                    if (r_op[1]) begin
                        r_acc <= w_div_next;
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= r_b >> 1;
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    if (!r_op[1]) begin
                        hi_wdata <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo_wdata <= w_prod_fix[WIDTH-1:0];
                    end else if (r_div_zero) begin
                        hi_wdata <= w_a_raw;
                        lo_wdata <= '1;
                    end else begin
                        hi_wdata <= w_rem_fix;
                        lo_wdata <= w_quo_fix;
                    end
                    hilo_we <= 1'b1;
                    r_state <= WRITE;
                end
                WRITE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Scoreboard bench for muldiv_seq with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         resetn = 1'b0;
    logic         start  = 1'b0;
    logic [1:0]   op     = 2'b00;
    logic [W-1:0] src_a  = '0;
    logic [W-1:0] src_b  = '0;
    logic         mf_req = 1'b0;
    logic         busy;
    logic         stall;
    logic         hilo_we;
    logic [W-1:0] hi_wdata;
    logic [W-1:0] lo_wdata;

    muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .mf_req  (mf_req),
        .busy    (busy),
        .stall   (stall),
        .hilo_we (hilo_we),
        .hi_wdata(hi_wdata),
        .lo_wdata(lo_wdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [2*W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every HI/LO write is checked against the oldest expected result.
    always @(negedge clk) begin : mon
        logic [2*W-1:0] e;
        if (hilo_we) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hilo_we actual=%h_%h required=no_write", hi_wdata, lo_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("hilo_result", {hi_wdata, lo_wdata}, e);
            end
        end
    end

    // Called at a negedge while idle; returns at the negedge of cycle 35.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] e, input string name);
        int n;
        op = o; src_a = a; src_b = b; start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        chk({name, "_busy_c1"}, busy, 1);
        while (!hilo_we && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_latency"}, n, 34);
        @(negedge clk);
        chk({name, "_idle_c35"}, busy, 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int p0;
        mf_req = 1'b1;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall, 0);
        chk("reset_we", hilo_we, 0);
        chk("reset_hilo", {hi_wdata, lo_wdata}, 64'h0);
        mf_req = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        run_op(2'b00, 32'hFFFFFFFF, 32'h00000002, 64'hFFFFFFFF_FFFFFFFE, "mult_m1x2");
        run_op(2'b01, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE, "multu_ffx2");
        run_op(2'b01, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "multu_min");
        run_op(2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, "mult_min");
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, "div_m7d2");
        run_op(2'b10, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, "div_7dm2");
        run_op(2'b11, 32'd100,      32'd7,        64'h00000002_0000000E, "divu_100d7");
        run_op(2'b11, 32'h12345678, 32'h00000000, 64'h12345678_FFFFFFFF, "divu_zero");
        run_op(2'b10, 32'hFFFFFFF9, 32'h00000000, 64'hFFFFFFF9_FFFFFFFF, "div_zero");
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, "div_ovf");

        // Stall window and ignored start while busy.
        p0 = pulses;
        op = 2'b00; src_a = 32'hFFFFFFFD; src_b = 32'h00000005;
        start = 1'b1; mf_req = 1'b1;
        exp_q.push_back(64'hFFFFFFFF_FFFFFFF1);
        #1;
        chk("stall_start_same_cycle", stall, 0);
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            mf_req = (n >= 5 && n <= 35);
            start  = (n == 10);
            if (n == 10) begin
                src_a = 32'h00000007;
                src_b = 32'h00000003;
            end
            #1;
            if (n >= 5 && n <= 35) chk($sformatf("stall_c%0d", n), stall, (n <= 34) ? 1 : 0);
            if (n == 34) chk("stall_we_c34", hilo_we, 1);
        end
        start = 1'b0; mf_req = 1'b0;
        chk("single_pulse", pulses - p0, 1);

        // Asynchronous abort mid-divide.
        @(negedge clk);
        p0 = pulses;
        op = 2'b11; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_we", hilo_we, 0);
        chk("abort_hilo", {hi_wdata, lo_wdata}, 64'h0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_pulse", pulses - p0, 0);
        chk("abort_idle", busy, 0);

        run_op(2'b01, 32'd3, 32'd5, 64'h00000000_0000000F, "multu_3x5");

        @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
